// File: rtl/brightness_adjust.sv
// brightness_adjust: saturating add/subtract of a shared offset on two RGB pixels, one-cycle registered latency.
module brightness_adjust #(
  parameter int IMG_PIX_W  = 8,
  parameter int WAVE_PIX_W = 10
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic [IMG_PIX_W-1:0] value,
  input  logic [IMG_PIX_W-1:0] r0,
  input  logic [IMG_PIX_W-1:0] g0,
  input  logic [IMG_PIX_W-1:0] b0,
  input  logic [IMG_PIX_W-1:0] r1,
  input  logic [IMG_PIX_W-1:0] g1,
  input  logic [IMG_PIX_W-1:0] b1,
  output logic                 out_valid,
  output logic [IMG_PIX_W-1:0] out_r0,
  output logic [IMG_PIX_W-1:0] out_g0,
  output logic [IMG_PIX_W-1:0] out_b0,
  output logic [IMG_PIX_W-1:0] out_r1,
  output logic [IMG_PIX_W-1:0] out_g1,
  output logic [IMG_PIX_W-1:0] out_b1
);
  localparam int PAD = WAVE_PIX_W - IMG_PIX_W;
  logic [IMG_PIX_W-1:0] w_in  [6];
  logic [IMG_PIX_W-1:0] w_sat [6];
  logic [IMG_PIX_W-1:0] r_out [6];
  logic                 r_valid;
  logic signed [WAVE_PIX_W-1:0] w_val;
  assign w_in  = '{r0, g0, b0, r1, g1, b1};
  assign w_val = $signed({{PAD{1'b0}}, value});
  for (genvar c = 0; c < 6; c++) begin : g_ch
    logic signed [WAVE_PIX_W-1:0] w_ch;
    logic signed [WAVE_PIX_W-1:0] w_t;
    assign w_ch = $signed({{PAD{1'b0}}, w_in[c]});
    assign w_t  = mode ? w_ch - w_val : w_ch + w_val;
    // sign bit means underflow; any set bit above the channel width means overflow
    assign w_sat[c] = w_t[WAVE_PIX_W-1] ? '0 :
                      |w_t[WAVE_PIX_W-2:IMG_PIX_W] ? '1 : w_t[IMG_PIX_W-1:0];
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      for (int i = 0; i < 6; i++) r_out[i] <= '0;
    end else begin
      r_valid <= in_valid;
      for (int i = 0; i < 6; i++) r_out[i] <= in_valid ? w_sat[i] : '0;
    end
  end
  assign out_valid = r_valid;
  assign out_r0    = r_out[0];
  assign out_g0    = r_out[1];
  assign out_b0    = r_out[2];
  assign out_r1    = r_out[3];
  assign out_g1    = r_out[4];
  assign out_b1    = r_out[5];
endmodule

// File: tb/tb_brightness_adjust.sv
// tb_brightness_adjust: scoreboard bench with a saturating-arithmetic reference model.
module tb_brightness_adjust;
  logic       HCLK = 0, HRESETn = 0, in_valid = 0, mode = 0;
  logic [7:0] value = 0;
  logic [7:0] px [6];
  logic [7:0] o  [6];
  logic       out_valid;
  typedef struct {bit v; int d[6];} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  brightness_adjust dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .mode(mode), .value(value),
    .r0(px[0]), .g0(px[1]), .b0(px[2]), .r1(px[3]), .g1(px[4]), .b1(px[5]),
    .out_valid(out_valid),
    .out_r0(o[0]), .out_g0(o[1]), .out_b0(o[2]), .out_r1(o[3]), .out_g1(o[4]), .out_b1(o[5])
  );
  always #5 HCLK = ~HCLK;
  function automatic int adj(int ch, int v, bit m);
    int t = m ? ch - v : ch + v;
    return t > 255 ? 255 : (t < 0 ? 0 : t);
  endfunction
  always @(posedge HCLK) begin
    exp_t e;
    if (HRESETn) begin
      e.v = in_valid;
      for (int i = 0; i < 6; i++) e.d[i] = in_valid ? adj(int'(px[i]), int'(value), mode) : 0;
      q.push_back(e);
    end
  end
  always @(negedge HCLK) begin
    exp_t e;
    bit bad;
    if (HRESETn && q.size() > 0) begin
      e = q.pop_front();
      bad = (out_valid !== e.v);
      for (int i = 0; i < 6; i++) if (o[i] !== 8'(e.d[i])) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL sb: got v=%0b %0d %0d %0d %0d %0d %0d, want v=%0b %0d %0d %0d %0d %0d %0d",
                 out_valid, o[0], o[1], o[2], o[3], o[4], o[5],
                 e.v, e.d[0], e.d[1], e.d[2], e.d[3], e.d[4], e.d[5]);
      end
    end
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic chk6(string nm, int exp[6]);
    chk({nm, "_v"}, int'(out_valid), 1);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_%0d", nm, i), int'(o[i]), exp[i]);
  endtask
  task automatic drive(bit v, bit m, int val, int p[6]);
    in_valid = v;
    mode     = m;
    value    = 8'(val);
    for (int i = 0; i < 6; i++) px[i] = 8'(p[i]);
  endtask
  task automatic drive_rand(bit v, bit m, int val);
    int p[6];
    for (int i = 0; i < 6; i++) p[i] = int'($urandom_range(255));
    drive(v, m, val, p);
  endtask
  initial begin
    drive(1, 0, 20, '{9, 8, 7, 6, 5, 4});
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_v", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("rst_d%0d", i), int'(o[i]), 0);
    @(posedge HCLK); #1;
    HRESETn = 1;
    drive(1, 0, 20, '{100, 0, 235, 1, 50, 200});
    #2 chk("lat_pre", int'(out_valid), 0);
    @(posedge HCLK); #1;
    chk6("bright", '{120, 20, 255, 21, 70, 220});
    drive(1, 0, 255, '{200, 200, 200, 200, 200, 200});
    @(posedge HCLK); #1;
    chk6("clip255", '{255, 255, 255, 255, 255, 255});
    drive(1, 0, 56, '{200, 199, 0, 56, 255, 100});
    @(posedge HCLK); #1;
    chk6("clip56", '{255, 255, 56, 112, 255, 156});
    drive(1, 1, 30, '{10, 30, 31, 255, 0, 100});
    @(posedge HCLK); #1;
    chk6("dark", '{0, 0, 1, 225, 0, 70});
    for (int k = 0; k < 20; k++) begin
      drive_rand(1, k[0], 0);
      @(posedge HCLK); #1;
    end
    drive_rand(0, 0, 77);
    @(posedge HCLK); #1;
    chk("gate_v", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("gate_d%0d", i), int'(o[i]), 0);
    for (int k = 0; k < 768; k++) begin
      drive_rand(1, ((k / 16) % 2) == 1, k % 256);
      @(posedge HCLK); #1;
    end
    drive(1, 0, 10, '{200, 150, 100, 50, 20, 5});
    @(posedge HCLK); #1;
    HRESETn = 0;
    q.delete();
    #1;
    chk("arst_v", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("arst_d%0d", i), int'(o[i]), 0);
    @(posedge HCLK); #1;
    HRESETn = 1;
    for (int k = 0; k < 10; k++) begin
      drive_rand(k != 4, $urandom_range(1) == 1, int'($urandom_range(255)));
      @(posedge HCLK); #1;
    end
    drive_rand(0, 0, 0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); #1;
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
